// File: rtl/dense_readout_pkg.sv
// Shared constants, state encoding and Q-format limits for the dense readout layer.
// Optional argmax output is enabled with DENSE_READOUT_ARGMAX_EN.
package dense_readout_pkg;

  // Geometry of the layer-2 pooled feature map this block reads
  localparam int unsigned POOL_H    = 13;
  localparam int unsigned POOL_W    = 13;
  localparam int unsigned POOL_C    = 8;
  localparam int unsigned POOL_N    = POOL_H * POOL_W * POOL_C;

  localparam int unsigned N_OUT_DEF = 10;
  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned ACC_W_DEF = 40;
  localparam int unsigned Q_W       = 16;
  localparam int unsigned PROD_W    = 2 * Q_W;

  localparam int unsigned INP_AW    = 11;
  localparam int unsigned W_AW      = 14;
  localparam int unsigned B_AW      = 4;
  localparam int unsigned O_AW      = 4;

  localparam logic signed [Q_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [Q_W-1:0] Q_MIN = 16'sh8000;

  // Narrowest accumulator that cannot wrap over n_in full-scale products
  function automatic int unsigned acc_w_min(input int unsigned n_in);
    return PROD_W + $clog2(n_in);
  endfunction

  function automatic int unsigned acc_w_fit(input int unsigned acc_w, input int unsigned n_in);
    return (acc_w >= acc_w_min(n_in)) ? acc_w : acc_w_min(n_in);
  endfunction

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLR      = 4'd1,
    S_SET_ADDR = 4'd2,
    S_BUF      = 4'd3,
    S_MAC      = 4'd4,
    S_BSET     = 4'd5,
    S_BBUF     = 4'd6,
    S_WRITE    = 4'd7,
    S_NEXT     = 4'd8,
    S_DONE     = 4'd9
  } state_e;

endpackage

// File: rtl/dense_readout_if.sv
// Layer handshake plus feature/weight/bias read ports and logit write port.
// pred/pred_valid exist only when DENSE_READOUT_ARGMAX_EN is defined.
interface dense_readout_if;
  import dense_readout_pkg::*;

  logic              valid;
  logic              ready;
  logic              done;
  logic [INP_AW-1:0] inp_addr;
  logic [Q_W-1:0]    inp_data;
  logic [W_AW-1:0]   w_addr;
  logic [Q_W-1:0]    w_data;
  logic [B_AW-1:0]   b_addr;
  logic [Q_W-1:0]    b_data;
  logic [O_AW-1:0]   out_addr;
  logic [Q_W-1:0]    out_data;
  logic              out_we;
`ifdef DENSE_READOUT_ARGMAX_EN
  logic [O_AW-1:0]   pred;
  logic              pred_valid;

  modport master (
    input  valid, inp_data, w_data, b_data,
    output ready, done, inp_addr, w_addr, b_addr, out_addr, out_data, out_we,
    output pred, pred_valid
  );
  modport slave (
    output valid, inp_data, w_data, b_data,
    input  ready, done, inp_addr, w_addr, b_addr, out_addr, out_data, out_we,
    input  pred, pred_valid
  );
`else
  modport master (
    input  valid, inp_data, w_data, b_data,
    output ready, done, inp_addr, w_addr, b_addr, out_addr, out_data, out_we
  );
  modport slave (
    output valid, inp_data, w_data, b_data,
    input  ready, done, inp_addr, w_addr, b_addr, out_addr, out_data, out_we
  );
`endif

endinterface

// File: rtl/dense_readout_fx_sat_shift.sv
// Floor (arithmetic) right shift by SHIFT followed by saturation to signed 16-bit Q-format.
// Shared by the dense readout WRITE path; independent of DENSE_READOUT_ARGMAX_EN.
module fx_sat_shift
  import dense_readout_pkg::*;
#(
  parameter int unsigned IN_W  = 41,
  parameter int unsigned SHIFT = FRAC_BITS
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [Q_W-1:0]  dout_c
);

  logic signed [IN_W-1:0] shr_c;

  assign shr_c = din >>> SHIFT;

  always_comb begin
    if (shr_c > IN_W'(Q_MAX)) begin
      dout_c = Q_MAX;
    end else if (shr_c < IN_W'(Q_MIN)) begin
      dout_c = Q_MIN;
    end else begin
      dout_c = shr_c[Q_W-1:0];
    end
  end

endmodule

// File: rtl/dense_readout.sv
// Fully-connected readout: N_OUT dot products of N_IN activations plus bias, written as 16-bit logits.
// Define DENSE_READOUT_ARGMAX_EN to add the pred/pred_valid argmax outputs.
module dense_readout
  import dense_readout_pkg::*;
#(
  parameter int unsigned N_IN  = POOL_N,
  parameter int unsigned N_OUT = N_OUT_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  dense_readout_if.master bus
);

  // Accumulator widened when ACC_W cannot hold N_IN full-scale products
  localparam int unsigned AW    = acc_w_fit(ACC_W, N_IN);
  localparam int unsigned SUM_W = AW + 1;

  state_e                   state_q, state_d;
  logic [INP_AW-1:0]        i_q, i_d;
  logic [O_AW-1:0]          n_q, n_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic                     ready_q, ready_d;
  logic                     done_q, done_d;
  logic                     out_we_q, out_we_d;
  logic [INP_AW-1:0]        inp_addr_q, inp_addr_d;
  logic [W_AW-1:0]          w_addr_q, w_addr_d;
  logic [B_AW-1:0]          b_addr_q, b_addr_d;
  logic [O_AW-1:0]          out_addr_q, out_addr_d;
  logic signed [Q_W-1:0]    out_data_q, out_data_d;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [Q_W-1:0]    logit_c;
`ifdef DENSE_READOUT_ARGMAX_EN
  logic signed [Q_W-1:0]    max_q, max_d;
  logic [O_AW-1:0]          arg_q, arg_d;
  logic [O_AW-1:0]          pred_q, pred_d;
  logic                     pred_valid_q, pred_valid_d;
`endif

  assign prod_c = PROD_W'($signed(bus.inp_data)) * PROD_W'($signed(bus.w_data));
  assign sum_c  = SUM_W'(acc_q) + (SUM_W'($signed(bus.b_data)) <<< FRAC_BITS);

  fx_sat_shift #(
    .IN_W  (SUM_W),
    .SHIFT (FRAC_BITS)
  ) u_sat (
    .din    (sum_c),
    .dout_c (logit_c)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    n_d        = n_q;
    acc_d      = acc_q;
    ready_d    = ready_q;
    done_d     = done_q;
    out_we_d   = out_we_q;
    inp_addr_d = inp_addr_q;
    w_addr_d   = w_addr_q;
    b_addr_d   = b_addr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
`ifdef DENSE_READOUT_ARGMAX_EN
    max_d        = max_q;
    arg_d        = arg_q;
    pred_d       = pred_q;
    pred_valid_d = pred_valid_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.valid) begin
          ready_d = 1'b0;
          n_d     = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        acc_d   = '0;
        i_d     = '0;
        state_d = S_SET_ADDR;
      end
      S_SET_ADDR: begin
        inp_addr_d = i_q;
        w_addr_d   = W_AW'(32'(n_q) * N_IN + 32'(i_q));
        state_d    = S_BUF;
      end
      S_BUF: state_d = S_MAC;
      S_MAC: begin
        acc_d = acc_q + AW'(prod_c);
        if (i_q == INP_AW'(N_IN - 1)) begin
          state_d = S_BSET;
        end else begin
          i_d     = i_q + INP_AW'(1);
          state_d = S_SET_ADDR;
        end
      end
      S_BSET: begin
        b_addr_d = B_AW'(n_q);
        state_d  = S_BBUF;
      end
      S_BBUF: state_d = S_WRITE;
      S_WRITE: begin
        out_data_d = logit_c;
        out_addr_d = n_q;
        out_we_d   = 1'b1;
        state_d    = S_NEXT;
`ifdef DENSE_READOUT_ARGMAX_EN
        // Strict compare keeps the lowest index on ties
        if (n_q == '0 || logit_c > max_q) begin
          max_d = logit_c;
          arg_d = n_q;
        end
`endif
      end
      S_NEXT: begin
        out_we_d = 1'b0;
        if (n_q == O_AW'(N_OUT - 1)) begin
          state_d = S_DONE;
`ifdef DENSE_READOUT_ARGMAX_EN
          pred_d       = arg_q;
          pred_valid_d = 1'b1;
`endif
        end else begin
          n_d     = n_q + O_AW'(1);
          state_d = S_CLR;
        end
      end
      S_DONE: done_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      out_we_q   <= 1'b0;
      inp_addr_q <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
`ifdef DENSE_READOUT_ARGMAX_EN
      max_q        <= '0;
      arg_q        <= '0;
      pred_q       <= '0;
      pred_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      out_we_q   <= out_we_d;
      inp_addr_q <= inp_addr_d;
      w_addr_q   <= w_addr_d;
      b_addr_q   <= b_addr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
`ifdef DENSE_READOUT_ARGMAX_EN
      max_q        <= max_d;
      arg_q        <= arg_d;
      pred_q       <= pred_d;
      pred_valid_q <= pred_valid_d;
`endif
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.inp_addr = inp_addr_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.b_addr   = b_addr_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_data = out_data_q;
  assign bus.out_we   = out_we_q;
`ifdef DENSE_READOUT_ARGMAX_EN
  assign bus.pred       = pred_q;
  assign bus.pred_valid = pred_valid_q;
`endif

endmodule

// File: tb/tb_dense_readout.sv
// Directed bench for dense_readout with a small N_IN; checks pred/pred_valid when
// DENSE_READOUT_ARGMAX_EN is defined.
`timescale 1ns/1ps
module tb_dense_readout;
  import dense_readout_pkg::*;

  localparam int TB_N_IN  = 4;
  localparam int TB_N_OUT = 10;
  localparam int PER_N    = 3 * TB_N_IN + 5;
  localparam int LAT      = TB_N_OUT * PER_N + 2;
  localparam int LIMIT    = LAT + 50;
  localparam int ABORT_AT = 4 * PER_N + 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  dense_readout_if drif ();

  dense_readout #(
    .N_IN  (TB_N_IN),
    .N_OUT (TB_N_OUT),
    .ACC_W (40)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (drif)
  );

  always #5 clk = ~clk;

  logic [15:0] inp_mem [0:2047];
  logic [15:0] w_mem   [0:16383];
  logic [15:0] b_mem   [0:15];
  logic [15:0] out_ram [0:15];
  longint      exp_logit [0:15];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          sb_n     = 0;
  bit          prev_we  = 1'b0;

  // Synchronous memories: data follows the registered address by one edge
  always @(posedge clk) begin
    drif.inp_data <= inp_mem[drif.inp_addr];
    drif.w_data   <= w_mem[drif.w_addr];
    drif.b_data   <= b_mem[drif.b_addr];
    if (drif.out_we) out_ram[drif.out_addr] <= drif.out_data;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint model_logit(input int n);
    longint acc = 0;
    longint r;
    for (int i = 0; i < TB_N_IN; i++)
      acc += longint'($signed(inp_mem[i])) * longint'($signed(w_mem[n * TB_N_IN + i]));
    r = acc + longint'($signed(b_mem[n])) * (longint'(1) << FRAC_BITS);
    r = r >>> FRAC_BITS;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r;
  endfunction

`ifdef DENSE_READOUT_ARGMAX_EN
  function automatic int model_argmax();
    int best = 0;
    for (int n = 1; n < TB_N_OUT; n++)
      if (exp_logit[n] > exp_logit[best]) best = n;
    return best;
  endfunction
`endif

  // Every logit write: one-cycle strobe, neurons in order, value from the model
  always @(negedge clk) begin
    if (reset && drif.out_we) begin
      check("we_single", longint'(prev_we), 0);
      check("out_addr", longint'(drif.out_addr), longint'(sb_n));
      if (sb_n < 16) check("out_data", longint'($signed(drif.out_data)), exp_logit[sb_n]);
      sb_n++;
    end
    prev_we = drif.out_we;
  end

  task automatic load(input int kind);
    int argl [10];
    argl = '{5, 9, 9, 2, 1, 0, -3, 9, 4, 7};
    for (int n = 0; n < 16; n++) b_mem[n] = '0;
    for (int i = 0; i < TB_N_IN; i++) inp_mem[i] = '0;
    for (int k = 0; k < TB_N_IN * TB_N_OUT; k++) w_mem[k] = '0;
    case (kind)
      0: for (int n = 0; n < TB_N_OUT; n++) b_mem[n] = 16'(n * 16);
      1: begin
        inp_mem[0] = 16'd256;
        for (int n = 0; n < TB_N_OUT; n++) w_mem[n * TB_N_IN] = 16'(n * 256);
      end
      2, 3: begin
        for (int i = 0; i < TB_N_IN; i++) inp_mem[i] = 16'h7FFF;
        for (int k = 0; k < TB_N_IN * TB_N_OUT; k++) w_mem[k] = (kind == 2) ? 16'h7FFF : 16'h8001;
      end
      4: begin
        inp_mem[0] = 16'd1;
        for (int n = 0; n < TB_N_OUT; n++) w_mem[n * TB_N_IN] = 16'hFFFF;
      end
      5: begin
        for (int i = 0; i < TB_N_IN; i++) inp_mem[i] = 16'(i * 301 - 500);
        for (int k = 0; k < TB_N_IN * TB_N_OUT; k++) w_mem[k] = 16'((k * 173) % 997 - 480);
        for (int n = 0; n < TB_N_OUT; n++) b_mem[n] = 16'(n * 37 - 150);
      end
      default: for (int n = 0; n < TB_N_OUT; n++) b_mem[n] = 16'(argl[n]);
    endcase
    for (int n = 0; n < TB_N_OUT; n++) exp_logit[n] = model_logit(n);
  endtask

  // Caller is at a negedge; asserts reset for one edge, checks cleared outputs, releases
  task automatic do_reset(input string tag);
    reset = 1'b0;
    drif.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rst_ready"}, longint'(drif.ready), 0);
    check({tag, "_rst_done"}, longint'(drif.done), 0);
    check({tag, "_rst_we"}, longint'(drif.out_we), 0);
    check({tag, "_rst_addrs"}, longint'({drif.inp_addr, drif.w_addr, drif.b_addr, drif.out_addr}), 0);
    check({tag, "_rst_data"}, longint'(drif.out_data), 0);
`ifdef DENSE_READOUT_ARGMAX_EN
    check({tag, "_rst_pred"}, longint'(drif.pred), 0);
    check({tag, "_rst_pred_valid"}, longint'(drif.pred_valid), 0);
`endif
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ready_after_rel"}, longint'(drif.ready), 1);
  endtask

  task automatic run(input string tag, input bit hold_valid, input int abort_at);
    int cyc;
    bit seen;
    sb_n = 0;
    cyc = 0;
    while (!drif.ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ready_idle"}, longint'(drif.ready), 1);
    drif.valid = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < LIMIT && (abort_at == 0 || cyc < abort_at)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        check({tag, "_ready_drop"}, longint'(drif.ready), 0);
        if (!hold_valid) drif.valid = 1'b0;
      end
      if (drif.done) seen = 1'b1;
    end
    if (abort_at != 0) return;
    check({tag, "_done_cycle"}, longint'(cyc), longint'(LAT));
    check({tag, "_writes"}, longint'(sb_n), longint'(TB_N_OUT));
    check({tag, "_ready_done"}, longint'(drif.ready), 0);
    for (int n = 0; n < TB_N_OUT; n++)
      check({tag, "_ram"}, longint'($signed(out_ram[n])), exp_logit[n]);
`ifdef DENSE_READOUT_ARGMAX_EN
    check({tag, "_pred"}, longint'(drif.pred), longint'(model_argmax()));
    check({tag, "_pred_valid"}, longint'(drif.pred_valid), 1);
`endif
    // A fresh valid while done must not restart the layer
    drif.valid = 1'b1;
    repeat (5) @(negedge clk);
    drif.valid = 1'b0;
    check({tag, "_done_hold"}, longint'(drif.done), 1);
    check({tag, "_no_rerun"}, longint'(sb_n), longint'(TB_N_OUT));
  endtask

  initial begin
    drif.valid = 1'b0;
    reset = 1'b0;
    load(0);
    do_reset("por");

    run("zero_bias", 1'b1, 0);
    for (int n = 0; n < TB_N_OUT; n++) check("lit_zero_bias", longint'($signed(out_ram[n])), longint'(n * 16));

    do_reset("r1");
    load(1);
    run("unit_w", 1'b0, 0);
    for (int n = 0; n < TB_N_OUT; n++) check("lit_unit_w", longint'($signed(out_ram[n])), longint'(n * 256));

    do_reset("r2");
    load(2);
    run("sat_pos", 1'b1, 0);
    for (int n = 0; n < TB_N_OUT; n++) check("lit_sat_pos", longint'($signed(out_ram[n])), 32767);

    do_reset("r3");
    load(3);
    run("sat_neg", 1'b0, 0);
    for (int n = 0; n < TB_N_OUT; n++) check("lit_sat_neg", longint'($signed(out_ram[n])), -32768);

    do_reset("r4");
    load(4);
    run("neg_trunc", 1'b1, 0);
    for (int n = 0; n < TB_N_OUT; n++) check("lit_neg_trunc", longint'(out_ram[n]), 65535);

    do_reset("r5");
    load(5);
    run("abort", 1'b1, ABORT_AT);
    check("abort_writes", longint'(sb_n), 4);
    do_reset("mid_run");
    for (int n = 0; n < 4; n++) check("abort_kept", longint'($signed(out_ram[n])), exp_logit[n]);
    run("rerun", 1'b1, 0);

    do_reset("r6");
    load(6);
    run("argmax", 1'b0, 0);
    check("lit_argmax_l1", longint'($signed(out_ram[1])), 9);
    check("lit_argmax_l6", longint'($signed(out_ram[6])), -3);
`ifdef DENSE_READOUT_ARGMAX_EN
    check("lit_pred", longint'(drif.pred), 1);
`endif
    @(negedge clk);
    do_reset("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
